// File: rtl/ras_ctrl_if.sv
// Signal bundle between fetch/pipeline control, ras_ctrl and the ras stack.
// The master side is the controller; the slave side is the surrounding pipeline and stack.
interface ras_ctrl_if #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned WIDTH  = XLEN - 1
);
  logic              fetch_valid;
  logic [XLEN-1:0]   fetch_pc;
  logic [31:0]       fetch_instr;
  logic [STAGES-1:0] stage_adv;
  logic [STAGES-1:0] kill;
  logic [WIDTH-1:0]  ras_dout;
  logic              ras_valid;

  logic              push;
  logic              pop;
  logic [WIDTH-1:0]  din;
  logic [STAGES-1:0] commit;
  logic [STAGES-1:0] flush;
  logic              pred_valid;
  logic [XLEN-1:0]   pred_target;
  logic [STAGES-1:0] occ;

  modport master (
    input  fetch_valid, fetch_pc, fetch_instr, stage_adv, kill, ras_dout, ras_valid,
    output push, pop, din, commit, flush, pred_valid, pred_target, occ
  );

  modport slave (
    output fetch_valid, fetch_pc, fetch_instr, stage_adv, kill, ras_dout, ras_valid,
    input  push, pop, din, commit, flush, pred_valid, pred_target, occ
  );
endinterface

// File: rtl/ras_ctrl.sv
// Return-address-stack front-end: decodes calls/returns into push/pop, tracks which
// speculative stages hold a stack op, and drives the stack's commit/flush vectors.
module ras_ctrl #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned WIDTH  = XLEN - 1
) (
  input logic      clk,
  input logic      rst_i,
  ras_ctrl_if.master bus
);

  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [2:0]        funct3;
  logic              is_jal;
  logic              is_jalr;
  logic              link_rd;
  logic              link_rs1;
  logic              dec_push;
  logic              dec_pop;
  logic              any_kill;
  logic              issue;
  logic [XLEN-1:0]   pc_plus4;
  logic [STAGES-1:0] flush;
  logic [STAGES-1:0] commit;
  logic [STAGES-1:0] occ_d;
  logic [STAGES-1:0] occ_q;

  assign opcode = bus.fetch_instr[6:0];
  assign rd     = bus.fetch_instr[11:7];
  assign funct3 = bus.fetch_instr[14:12];
  assign rs1    = bus.fetch_instr[19:15];

  assign is_jal   = (opcode == OpJal);
  assign is_jalr  = (opcode == OpJalr) && (funct3 == 3'b000);
  assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
  assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

  // JALR with rd==rs1 (both link regs) is a plain call, not a coroutine swap.
  assign dec_push = (is_jal || is_jalr) && link_rd;
  assign dec_pop  = is_jalr && link_rs1 && (!link_rd || (rd != rs1));

  assign any_kill = |bus.kill;
  assign issue    = bus.fetch_valid && !any_kill && !rst_i && (dec_push || dec_pop);

  assign pc_plus4 = bus.fetch_pc + XLEN'(4);

  assign bus.push        = issue && dec_push;
  assign bus.pop         = issue && dec_pop;
  assign bus.din         = pc_plus4[XLEN-1:1];
  assign bus.pred_valid  = issue && dec_pop && bus.ras_valid;
  assign bus.pred_target = {bus.ras_dout, 1'b0};

  // A kill at stage k squashes every younger stage, so flush is a suffix OR.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    flush = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc      = acc | bus.kill[i];
      flush[i] = acc;
    end
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < STAGES; i++) begin
      commit[i] = bus.stage_adv[i] && occ_q[i] && !flush[i] && !rst_i;
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush[0]) begin
      occ_d[0] = 1'b0;
    end else if (issue) begin
      occ_d[0] = 1'b1;
    end else if (bus.stage_adv[0]) begin
      occ_d[0] = 1'b0;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (flush[i]) begin
        occ_d[i] = 1'b0;
      end else if (bus.stage_adv[i-1]) begin
        // The stage below may itself be the oldest killed stage; its content is squashed.
        occ_d[i] = occ_q[i-1] && !flush[i-1];
      end else if (bus.stage_adv[i]) begin
        occ_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.flush  = flush;
  assign bus.commit = commit;
  assign bus.occ    = occ_q;

  logic unused_bits;
  assign unused_bits = ^{bus.fetch_instr[31:20], pc_plus4[0]};

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: decode table, prediction, commit chain, kill and reset.
module tb_ras_ctrl;
  localparam int unsigned STAGES = 2;
  localparam int unsigned XLEN   = 32;

  localparam logic [31:0] JalX1      = 32'h0000_00EF;
  localparam logic [31:0] JalX5      = 32'h0000_02EF;
  localparam logic [31:0] JalX0      = 32'h0000_006F;
  localparam logic [31:0] JalrX0X1   = 32'h0000_8067;
  localparam logic [31:0] JalrX5X1   = 32'h0000_82E7;
  localparam logic [31:0] JalrX1X1   = 32'h0000_80E7;
  localparam logic [31:0] JalrX1X2   = 32'h0001_00E7;
  localparam logic [31:0] JalrX0X5   = 32'h0002_8067;
  localparam logic [31:0] JalrX5X5   = 32'h0002_82E7;
  localparam logic [31:0] JalrX1X5   = 32'h0002_80E7;
  localparam logic [31:0] JalrF3X1X1 = 32'h0000_90E7;
  localparam logic [31:0] Addi       = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_i;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ras_ctrl_if #(.STAGES(STAGES), .XLEN(XLEN)) bus ();

  ras_ctrl #(.STAGES(STAGES), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [1:0] adv, input logic [1:0] kl);
    bus.fetch_valid = fv;
    bus.fetch_pc    = pc;
    bus.fetch_instr = instr;
    bus.stage_adv   = adv;
    bus.kill        = kl;
  endtask

  // One decode case, held only during the low phase so no op is ever clocked in.
  task automatic dec(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                     input logic exp_push, input logic exp_pop);
    @(negedge clk);
    drive(1'b1, pc, instr, 2'b00, 2'b00);
    #1;
    chk({tag, ".push"}, 32'(bus.push), 32'(exp_push));
    chk({tag, ".pop"}, 32'(bus.pop), 32'(exp_pop));
    bus.fetch_valid = 1'b0;
  endtask

  // Two back-to-back calls leave both stages occupied.
  task automatic fill_occ11();
    @(negedge clk);
    drive(1'b1, 32'h1000, JalX1, 2'b00, 2'b00);
    @(negedge clk);
    drive(1'b1, 32'h1010, JalX1, 2'b01, 2'b00);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("fill.occ", 32'(bus.occ), 32'h3);
  endtask

  initial begin
    rst_i         = 1'b1;
    bus.ras_dout  = '0;
    bus.ras_valid = 1'b0;
    drive(1'b1, 32'h1000, JalX1, 2'b11, 2'b10);

    // Reset: ops and commits suppressed, flush still follows kill.
    @(negedge clk);
    #1;
    chk("rst.push", 32'(bus.push), 32'h0);
    chk("rst.commit", 32'(bus.commit), 32'h0);
    chk("rst.flush", 32'(bus.flush), 32'h3);
    @(negedge clk);
    chk("rst.occ", 32'(bus.occ), 32'h0);
    rst_i = 1'b0;
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);

    // JAL call
    @(negedge clk);
    drive(1'b1, 32'h1000, JalX1, 2'b00, 2'b00);
    #1;
    chk("jal.push", 32'(bus.push), 32'h1);
    chk("jal.pop", 32'(bus.pop), 32'h0);
    chk("jal.din", 32'(bus.din), 32'h802);
    chk("jal.pred_valid", 32'(bus.pred_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("jal.occ", 32'(bus.occ), 32'h1);

    // Hold, then commit chain
    @(negedge clk);
    chk("hold.occ", 32'(bus.occ), 32'h1);
    drive(1'b0, 32'h0, Addi, 2'b01, 2'b00);
    #1;
    chk("chain.commit0", 32'(bus.commit), 32'h1);
    @(negedge clk);
    chk("chain.occ10", 32'(bus.occ), 32'h2);
    drive(1'b0, 32'h0, Addi, 2'b10, 2'b00);
    #1;
    chk("chain.commit1", 32'(bus.commit), 32'h2);
    @(negedge clk);
    chk("chain.occ00", 32'(bus.occ), 32'h0);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);

    // Return with valid top of stack
    @(negedge clk);
    bus.ras_dout  = 31'h802;
    bus.ras_valid = 1'b1;
    drive(1'b1, 32'h2000, JalrX0X1, 2'b00, 2'b00);
    #1;
    chk("ret.pop", 32'(bus.pop), 32'h1);
    chk("ret.push", 32'(bus.push), 32'h0);
    chk("ret.pred_valid", 32'(bus.pred_valid), 32'h1);
    chk("ret.pred_target", bus.pred_target, 32'h1004);
    bus.ras_valid = 1'b0;
    #1;
    chk("ret.pred_invalid", 32'(bus.pred_valid), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b01, 2'b00);
    chk("ret.occ", 32'(bus.occ), 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b10, 2'b00);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("ret.drain", 32'(bus.occ), 32'h0);

    // Decode table
    @(negedge clk);
    drive(1'b1, 32'h3000, JalrX5X1, 2'b00, 2'b00);
    #1;
    chk("co.din", 32'(bus.din), 32'h1802);
    bus.fetch_valid = 1'b0;
    dec("co.x5x1", 32'h3000, JalrX5X1, 1'b1, 1'b1);
    dec("co.x1x1", 32'h3000, JalrX1X1, 1'b1, 1'b0);
    dec("jalr.x1x2", 32'h3000, JalrX1X2, 1'b1, 1'b0);
    dec("jalr.x0x5", 32'h3000, JalrX0X5, 1'b0, 1'b1);
    dec("jalr.x5x5", 32'h3000, JalrX5X5, 1'b1, 1'b0);
    dec("jalr.x1x5", 32'h3000, JalrX1X5, 1'b1, 1'b1);
    dec("jalr.f3", 32'h3000, JalrF3X1X1, 1'b0, 1'b0);
    dec("jal.x0", 32'h3000, JalX0, 1'b0, 1'b0);
    dec("jal.x5", 32'h3000, JalX5, 1'b1, 1'b0);
    dec("addi", 32'h3000, Addi, 1'b0, 1'b0);
    @(negedge clk);
    chk("dec.occ", 32'(bus.occ), 32'h0);

    // Kill suppresses a fetched call
    drive(1'b1, 32'h1000, JalX1, 2'b00, 2'b01);
    #1;
    chk("killfetch.push", 32'(bus.push), 32'h0);
    chk("killfetch.flush", 32'(bus.flush), 32'h1);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("killfetch.occ", 32'(bus.occ), 32'h0);

    // Partial kill at stage 0 with full advance
    fill_occ11();
    drive(1'b0, 32'h0, Addi, 2'b11, 2'b01);
    #1;
    chk("kill01.flush", 32'(bus.flush), 32'h1);
    chk("kill01.commit", 32'(bus.commit), 32'h2);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("kill01.occ", 32'(bus.occ), 32'h0);

    // Kill at stage 1 with full advance
    fill_occ11();
    drive(1'b0, 32'h0, Addi, 2'b11, 2'b10);
    #1;
    chk("kill10.flush", 32'(bus.flush), 32'h3);
    chk("kill10.commit", 32'(bus.commit), 32'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("kill10.occ", 32'(bus.occ), 32'h0);

    // Reset mid-operation
    fill_occ11();
    rst_i = 1'b1;
    drive(1'b1, 32'h1000, JalX1, 2'b11, 2'b00);
    #1;
    chk("rstmid.commit", 32'(bus.commit), 32'h0);
    chk("rstmid.push", 32'(bus.push), 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    drive(1'b0, 32'h0, Addi, 2'b00, 2'b00);
    chk("rstmid.occ", 32'(bus.occ), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
